// File: rtl/lsu_pkg.sv
// Shared types and default memory window for the load/store unit.
// LSU_BOUNDS_CHECK_EN selects the optional address range check.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  localparam logic [7:0] DEF_MEM_BASE  = 8'd64;
  localparam logic [7:0] DEF_MEM_LIMIT = 8'd127;

endpackage

// File: rtl/lsu_addr_check.sv
// Combinational data-window comparator for the load/store unit.
// Instantiated only when LSU_BOUNDS_CHECK_EN is defined.
module lsu_addr_check
  import lsu_pkg::*;
#(
  parameter logic [7:0] BASE  = DEF_MEM_BASE,
  parameter logic [7:0] LIMIT = DEF_MEM_LIMIT
) (
  input  logic [7:0] addr,
  output logic       fault
);

  assign fault = (addr < BASE) || (addr > LIMIT);

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with a synchronous data memory port.
// Define LSU_BOUNDS_CHECK_EN to fault accesses outside MEM_BASE..MEM_LIMIT.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter logic [7:0] MEM_BASE  = DEF_MEM_BASE,
  parameter logic [7:0] MEM_LIMIT = DEF_MEM_LIMIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_is_store,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_rdata,
  output logic       resp_fault,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  lsu_state_t state;
  lsu_state_t state_nxt;

  logic       is_store_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;
  logic       addr_fault;
  logic       accept;
  logic       in_access;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign in_access = (state == ACCESS);

`ifdef LSU_BOUNDS_CHECK_EN
  logic fault_q;

  lsu_addr_check #(
    .BASE  (MEM_BASE),
    .LIMIT (MEM_LIMIT)
  ) u_addr_check (
    .addr  (req_addr),
    .fault (addr_fault)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (accept) begin
      fault_q <= addr_fault;
    end
  end

  assign resp_fault = fault_q;
`else
  logic unused_cfg;

  assign unused_cfg = ^{MEM_BASE, MEM_LIMIT};
  assign addr_fault = 1'b0;
  assign resp_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = addr_fault ? RESP : ACCESS;
        end
      end
      ACCESS:  state_nxt = is_store_q ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // rdata is cleared on accept so stores and faults answer with zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else if (accept) begin
      is_store_q <= req_is_store;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      rdata_q    <= '0;
    end else if (state == CAPTURE) begin
      rdata_q    <= mem_rdata;
    end
  end

  assign mem_we     = in_access & is_store_q;
  assign mem_addr   = in_access ? addr_q  : '0;
  assign mem_wdata  = in_access ? wdata_q : '0;
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus hold and reset cases.
// Expectations follow LSU_BOUNDS_CHECK_EN when it is defined.
module tb_load_store_unit;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_is_store;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_rdata;
  logic       resp_fault;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;

`ifdef LSU_BOUNDS_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic [7:0] mem [256];

  load_store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory model, preloaded while reset is held
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h46] <= 8'h5A;
      mem[8'h3F] <= 8'h77;
      mem_rdata  <= 8'h00;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  typedef struct {
    logic       st;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       fault;
    int         lat;
    int         we;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int we0;
    @(negedge clk);
    chk($sformatf("v%0d req_ready", idx), 32'(req_ready), 32'd1);
    we0          = we_cnt;
    req_valid    = 1'b1;
    req_is_store = v.st;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d rdata", idx), 32'(resp_rdata), 32'(v.rdata));
    chk($sformatf("v%0d fault", idx), 32'(resp_fault), 32'(v.fault));
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk($sformatf("v%0d we_cycles", idx), 32'(we_cnt - we0), 32'(v.we));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int we0;

    tv[0] = '{1'b0, 8'h46, 8'h00, 8'h5A, 1'b0, 2, 0};
    tv[1] = '{1'b1, 8'h40, 8'hC3, 8'h00, 1'b0, 1, 1};
    tv[2] = '{1'b0, 8'h40, 8'h00, 8'hC3, 1'b0, 2, 0};
    tv[3] = '{1'b1, 8'h7F, 8'h11, 8'h00, 1'b0, 1, 1};
    tv[4] = '{1'b0, 8'h7F, 8'h00, 8'h11, 1'b0, 2, 0};
    if (CHK) begin
      tv[5] = '{1'b0, 8'h3F, 8'h00, 8'h00, 1'b1, 0, 0};
      tv[6] = '{1'b1, 8'h80, 8'h99, 8'h00, 1'b1, 0, 0};
    end else begin
      tv[5] = '{1'b0, 8'h3F, 8'h00, 8'h77, 1'b0, 2, 0};
      tv[6] = '{1'b1, 8'h80, 8'h99, 8'h00, 1'b0, 1, 1};
    end
    tv[7] = '{1'b0, 8'h40, 8'h00, 8'hC3, 1'b0, 2, 0};

    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_is_store = 1'b0;
    req_addr     = 8'h00;
    req_wdata    = 8'h00;
    resp_ready   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst rdata", 32'(resp_rdata), 32'd0);
    chk("rst fault", 32'(resp_fault), 32'd0);
    chk("rst mem_we", 32'(mem_we), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(tv[i], i);

    // Response held back: outputs stable, new request ignored
    @(negedge clk);
    we0          = we_cnt;
    req_valid    = 1'b1;
    req_is_store = 1'b0;
    req_addr     = 8'h46;
    @(negedge clk);
    req_is_store = 1'b1;
    req_addr     = 8'h41;
    req_wdata    = 8'hEE;
    lat = 0;
    while (!resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("hold latency", 32'(lat), 32'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("hold%0d rdata", k), 32'(resp_rdata), 32'h5A);
      chk($sformatf("hold%0d ready", k), 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("hold req_ready", 32'(req_ready), 32'd1);
    chk("hold no write", 32'(we_cnt - we0), 32'd0);
    chk("hold mem41", 32'(mem[8'h41]), 32'd0);

    // Reset in the middle of a store access
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_addr     = 8'h50;
    req_wdata    = 8'h66;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("acc mem_we", 32'(mem_we), 32'd1);
    chk("acc mem_addr", 32'(mem_addr), 32'h50);
    #1 rst_n = 1'b0;
    #1;
    chk("arst mem_we", 32'(mem_we), 32'd0);
    chk("arst mem_addr", 32'(mem_addr), 32'd0);
    chk("arst req_ready", 32'(req_ready), 32'd1);
    chk("arst resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post resp_valid", 32'(resp_valid), 32'd0);
    chk("post req_ready", 32'(req_ready), 32'd1);
    chk("post mem50", 32'(mem[8'h50]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BASE, default 64, lowest legal data address.
REQ-002 SHALL have parameter MEM_LIMIT, default 127, highest legal data address.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  in  1  core presents a load/store request.
REQ-006 SHALL have port req_ready  out  1  unit can accept a request this cycle.
REQ-007 SHALL have port req_is_store  in  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  in  8  byte address.
REQ-009 SHALL have port req_wdata  in  8  store data.
REQ-010 SHALL have port resp_valid  out  1  response available.
REQ-011 SHALL have port resp_ready  in  1  core accepts the response.
REQ-012 SHALL have port resp_rdata  out  8  load data; 0 for stores and faults.
REQ-013 SHALL have port resp_fault  out  1  address outside MEM_BASE..MEM_LIMIT.
REQ-014 SHALL have port mem_addr  out  8  to data memory address.
REQ-015 SHALL have port mem_wdata  out  8  to data memory write data.
REQ-016 SHALL have port mem_we  out  1  to data memory write enable.
REQ-017 SHALL have port mem_rdata  in  8  from data memory; valid one posedge after mem_addr is presented with mem_we=0.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, CAPTURE, RESP.
REQ-019 IDLE: req_ready=1; all other states: req_ready=0.
REQ-020 On req_valid&req_ready, SHALL latch req_is_store, req_addr and req_wdata.
REQ-021 IDLE->RESP on accept of a faulting address, with no memory access and mem_we never asserted.
REQ-022 IDLE->ACCESS on accept of a legal address.
REQ-023 ACCESS: mem_addr=latched addr; mem_we=1 only for a store; mem_wdata=latched data.
REQ-024 ACCESS->RESP for stores; ACCESS->CAPTURE for loads.
REQ-025 CAPTURE: SHALL register mem_rdata into resp_rdata, then go to RESP.
REQ-026 RESP: resp_valid=1; resp_rdata and resp_fault SHALL remain stable until resp_ready=1, then go to IDLE.
REQ-027 Latency from the accepting edge to resp_valid: load 2 cycles, store 1 cycle, fault 0 cycles (visible the cycle after accept).
REQ-028 mem_we SHALL be 0 in every state except ACCESS-store, so idle cycles never write memory.
REQ-029 Boundary addresses MEM_BASE and MEM_LIMIT SHALL be legal; MEM_BASE-1 and MEM_LIMIT+1 SHALL fault.
REQ-030 A request presented while req_ready=0 SHALL be ignored; the core holds it.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset asserted in ACCESS SHALL drop mem_we the same instant; the pending transaction is discarded with no response.

Configuration
REQ-033 Macro LSU_BOUNDS_CHECK_EN: when defined, range checking per REQ-021/REQ-029 applies.
REQ-034 Without LSU_BOUNDS_CHECK_EN: all addresses are treated as legal, resp_fault is tied 0, and the FSM never takes IDLE->RESP directly.

Structure
REQ-035 Shared package lsu_pkg SHALL hold the FSM state enum and the default MEM_BASE/MEM_LIMIT constants.
REQ-036 Sub-module lsu_addr_check (combinational range comparator) SHALL be instantiated only under LSU_BOUNDS_CHECK_EN.

Verification
REQ-037 Load 0x46, memory[0x46]=0x5A preloaded -> resp_valid 2 cycles after accept, rdata=0x5A, fault=0.
REQ-038 Store 0x40 data 0xC3, then load 0x40 -> mem_we high exactly one cycle; load returns 0xC3.
REQ-039 Load 0x3F and store 0x80 (checking on) -> fault=1, rdata=0, mem_we never high; without macro -> fault=0.
REQ-040 resp_ready held 0 for 5 cycles -> resp_valid/rdata stable, req_ready=0 throughout, new req_valid ignored.
REQ-041 rst_n pulled low during store ACCESS -> mem_we=0 immediately, no response, req_ready=1 after release.
